bp_be_issue_queue_nwide: RTL and testbench
==========================================

// Module: bp_be_issue_queue_nwide
// PURPOSE
//  N-lane FE->BE instruction queue with speculative read and checkpointed commit, for multi-issue BE.
//  Accepts up to lanes_p fetch packets/cycle, presents up to lanes_p oldest unread entries to the
//  scheduler, and keeps issued-but-uncommitted entries for replay.
//  Three pointers: wptr (enqueue), rptr (speculative issue) and cptr (commit checkpoint).
//  roll replays from the checkpoint; clr flushes unread entries.
// PARAMETERS
//  entry_width_p  128  payload bits per entry (fe_queue packet width)
//  els_p          16   entries; power of two, >= 2*lanes_p
//  lanes_p        2    enqueue/issue/commit lanes per cycle, 1..4
//  (derived) ptr_w = clog2(els_p)+1 (wrap bit); cnt_w = clog2(lanes_p+1)
// PORTS
//  clk_i          in   1                  clock
//  reset_i        in   1                  async active-high reset
//  enq_v_i        in   lanes_p            per-lane enqueue valid; must be a prefix (lane k => lane k-1)
//  enq_data_i     in   lanes_p*entry_w    lane k payload at [k*entry_width_p +: entry_width_p]
//  enq_ready_o    out  1                  free slots >= lanes_p and ~clr_v_i
//  deq_v_o        out  lanes_p            lane k valid: unread count > k and ~roll_v_i
//  deq_data_o     out  lanes_p*entry_w    entry at rptr+k
//  deq_yumi_cnt_i in   cnt_w              entries consumed this cycle, <= popcount(deq_v_o)
//  commit_cnt_i   in   cnt_w              entries retired this cycle, <= (rptr-cptr)
//  roll_v_i       in   1                  replay: rptr returns to checkpoint
//  clr_v_i        in   1                  flush unread entries: wptr returns to rptr
//  occupancy_o    out  ptr_w              wptr-cptr (live + uncommitted entries)
// BEHAVIOUR
//  Reset (async, immediate): wptr=rptr=cptr=0; deq_v_o=0, enq_ready_o=0 while reset_i high.
//   Storage is not reset. Mid-operation reset discards all contents.
//   First cycle after release: enq_ready_o=1, occupancy_o=0.
//  Pointer arithmetic is modulo 2*els_p on ptr_w bits; index = ptr[ptr_w-2:0].
//   empty: rptr==wptr (all bits). full: wptr-cptr==els_p.
//  enq_cnt = popcount(enq_v_i) if enq_ready_o else 0. Lane k writes slot wptr+k.
//   wptr_n = wptr+enq_cnt. A non-prefix enq_v_i is illegal (assertion).
//  Data written in cycle t is visible on deq_data_o in t+1; no same-cycle bypass.
//  deq_data_o is combinational from storage at rptr+k. Lanes >= unread count hold don't-care data.
//  Normal: rptr_n = rptr+deq_yumi_cnt_i; cptr_n = cptr+commit_cnt_i.
//  roll_v_i: rptr_n = cptr+commit_cnt_i; deq_yumi_cnt_i ignored; deq_v_o=0 that cycle.
//   Commit still applies.
//  clr_v_i: wptr_n = rptr_n (the post-yumi/post-roll value); enqueue suppressed, enq_ready_o=0.
//  roll_v_i and clr_v_i together: rptr_n = wptr_n = cptr+commit_cnt_i; queue drains to empty.
//  Priority: reset > roll (read side) > yumi; clr > enq (write side); commit always applies.
//  Wrap: lanes straddling the index wrap (rptr+k, wptr+k) index modulo els_p.
//   Entries are contiguous in logical order.
//  Illegal (assertions, behaviour undefined): yumi > valid lanes; commit past rptr;
//   enq while ~enq_ready_o.
//  occupancy_o and enq_ready_o derive from registered pointers only; no input-to-ready path.
// TESTING (els_p=8, lanes_p=2)
//  1 Reset/fill: enqueue A,B then C,D on 2 cycles -> cycle 3 deq_v_o=11, data A,B; occupancy_o=4.
//  2 Full: enqueue 8 entries, no commit -> enq_ready_o=0 at occupancy 7 and 8.
//    commit_cnt_i=2 -> ready=1 next cycle.
//  3 Roll: issue A,B (yumi 2), commit 1, assert roll -> next cycle deq_data_o lane0=B, lane1=C.
//  4 Clear: 4 unread entries, yumi 1 plus clr_v_i -> wptr=rptr=1, deq_v_o=00.
//    Issued A is still committable.
//  5 Wrap: pointers at index 7, enqueue X,Y -> X at slot 7, Y at slot 0.
//    Next cycle deq_data_o lane0=X, lane1=Y.
//  6 Async reset mid-flow: assert reset_i between edges with 5 entries held ->
//    deq_v_o=0 immediately, occupancy_o=0 after release.

Source files
------------

// File: rtl/bp_be_issue_queue_nwide_if.sv
// bp_be_issue_queue_nwide_if: enqueue/issue/commit bundle of the N-wide issue queue
interface bp_be_issue_queue_nwide_if #(
  parameter int entry_width_p = 128,
  parameter int els_p = 16,
  parameter int lanes_p = 2
);
  localparam int ptr_w = $clog2(els_p) + 1;
  localparam int cnt_w = $clog2(lanes_p + 1);
  logic [lanes_p-1:0] enq_v_i;
  logic [lanes_p*entry_width_p-1:0] enq_data_i;
  logic enq_ready_o;
  logic [lanes_p-1:0] deq_v_o;
  logic [lanes_p*entry_width_p-1:0] deq_data_o;
  logic [cnt_w-1:0] deq_yumi_cnt_i;
  logic [cnt_w-1:0] commit_cnt_i;
  logic roll_v_i;
  logic clr_v_i;
  logic [ptr_w-1:0] occupancy_o;
  modport slave (
    input enq_v_i, enq_data_i, deq_yumi_cnt_i, commit_cnt_i, roll_v_i, clr_v_i,
    output enq_ready_o, deq_v_o, deq_data_o, occupancy_o
  );
  modport master (
    output enq_v_i, enq_data_i, deq_yumi_cnt_i, commit_cnt_i, roll_v_i, clr_v_i,
    input enq_ready_o, deq_v_o, deq_data_o, occupancy_o
  );
endinterface

// File: rtl/bp_be_issue_queue_nwide.sv
// bp_be_issue_queue_nwide: N-lane FE->BE queue with speculative issue pointer and commit checkpoint
module bp_be_issue_queue_nwide #(
  parameter int entry_width_p = 128,
  parameter int els_p = 16,
  parameter int lanes_p = 2
) (
  input logic clk_i,
  input logic reset_i,
  bp_be_issue_queue_nwide_if.slave q
);
  localparam int idx_w = $clog2(els_p);
  localparam int ptr_w = idx_w + 1;
  logic [ptr_w-1:0] wptr_q, wptr_d, rptr_q, rptr_d, cptr_q, cptr_d;
  logic [ptr_w-1:0] unread, occ, enq_cnt, req_cnt;
  logic ready;
  logic [entry_width_p-1:0] mem_q [els_p];
  always_comb begin
    occ = wptr_q - cptr_q;
    unread = wptr_q - rptr_q;
    ready = ~reset_i & ~q.clr_v_i & ((ptr_w'(els_p) - occ) >= ptr_w'(lanes_p));
    req_cnt = '0;
    for (int k = 0; k < lanes_p; k++) req_cnt = req_cnt + ptr_w'(q.enq_v_i[k]);
    enq_cnt = ready ? req_cnt : '0;
    cptr_d = cptr_q + ptr_w'(q.commit_cnt_i);
    rptr_d = q.roll_v_i ? cptr_d : rptr_q + ptr_w'(q.deq_yumi_cnt_i);
    wptr_d = q.clr_v_i ? rptr_d : wptr_q + enq_cnt;
    q.enq_ready_o = ready;
    q.occupancy_o = occ;
    q.deq_v_o = '0;
    q.deq_data_o = '0;
    for (int k = 0; k < lanes_p; k++) begin
      q.deq_v_o[k] = ~reset_i & ~q.roll_v_i & (unread > ptr_w'(k));
      q.deq_data_o[k*entry_width_p +: entry_width_p] = mem_q[idx_w'(rptr_q + ptr_w'(k))];
    end
  end
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cptr_q <= cptr_d;
    end
  end
  // payload storage is intentionally unreset; pointers alone define validity
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < lanes_p; k++)
      if (ptr_w'(k) < enq_cnt)
        mem_q[idx_w'(wptr_q + ptr_w'(k))] <= q.enq_data_i[k*entry_width_p +: entry_width_p];
  end
  a_enq_prefix: assert property (@(posedge clk_i) disable iff (reset_i)
    (q.enq_v_i & (q.enq_v_i + lanes_p'(1))) == '0);
  a_enq_ready: assert property (@(posedge clk_i) disable iff (reset_i)
    !(|q.enq_v_i && !q.enq_ready_o));
  a_yumi: assert property (@(posedge clk_i) disable iff (reset_i)
    q.roll_v_i || (int'(q.deq_yumi_cnt_i) <= $countones(q.deq_v_o)));
  a_commit: assert property (@(posedge clk_i) disable iff (reset_i)
    ptr_w'(q.commit_cnt_i) <= (rptr_q - cptr_q));
endmodule

// File: tb/tb_bp_be_issue_queue_nwide.sv
// tb_bp_be_issue_queue_nwide: directed scenarios plus random traffic against a queue-based model
module tb_bp_be_issue_queue_nwide;
  localparam int W = 32;
  localparam int E = 8;
  localparam int L = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  bp_be_issue_queue_nwide_if #(.entry_width_p(W), .els_p(E), .lanes_p(L)) bus ();
  bp_be_issue_queue_nwide #(.entry_width_p(W), .els_p(E), .lanes_p(L)) dut (
    .clk_i(clk),
    .reset_i(rst),
    .q(bus)
  );
  int n_cmp = 0;
  int n_err = 0;
  // model: mq holds entries from the commit checkpoint onward; the first nrd are issued
  logic [W-1:0] mq [$];
  int nrd = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic drive(input int ne, input logic [W-1:0] d0, d1, input int yumi, cm, input bit roll, clr);
    bus.enq_v_i = L'((1 << ne) - 1);
    bus.enq_data_i = {d1, d0};
    bus.deq_yumi_cnt_i = 2'(yumi);
    bus.commit_cnt_i = 2'(cm);
    bus.roll_v_i = roll;
    bus.clr_v_i = clr;
  endtask
  function automatic bit exp_ready(input bit clr);
    return !clr && (E - mq.size() >= L);
  endfunction
  task automatic step(input int ne, input logic [W-1:0] d0, d1, input int yumi, cm, input bit roll, clr);
    int unr;
    bit rdy;
    @(negedge clk);
    drive(ne, d0, d1, yumi, cm, roll, clr);
    #1;
    rdy = exp_ready(clr);
    unr = mq.size() - nrd;
    chk("occupancy", 64'(bus.occupancy_o), 64'(mq.size()));
    chk("enq_ready", 64'(bus.enq_ready_o), 64'(rdy));
    for (int k = 0; k < L; k++) begin
      chk($sformatf("deq_v[%0d]", k), 64'(bus.deq_v_o[k]), 64'(!roll && unr > k));
      if (!roll && unr > k)
        chk($sformatf("deq_data[%0d]", k), 64'(bus.deq_data_o[k*W +: W]), 64'(mq[nrd+k]));
    end
    @(posedge clk);
    repeat (cm) void'(mq.pop_front());
    nrd = roll ? 0 : nrd + yumi - cm;
    if (clr) begin
      while (mq.size() > nrd) void'(mq.pop_back());
    end else if (rdy) begin
      if (ne > 0) mq.push_back(d0);
      if (ne > 1) mq.push_back(d1);
    end
  endtask
  task automatic peek();
    @(negedge clk);
    drive(0, '0, '0, 0, 0, 1'b0, 1'b0);
    #1;
  endtask
  task automatic do_reset();
    @(negedge clk);
    drive(0, '0, '0, 0, 0, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_deq_v", 64'(bus.deq_v_o), 64'(0));
    chk("rst_enq_ready", 64'(bus.enq_ready_o), 64'(0));
    chk("rst_occupancy", 64'(bus.occupancy_o), 64'(0));
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    mq.delete();
    nrd = 0;
  endtask
  initial begin
    int ne, yumi, cm, unr, vl;
    bit roll, clr;
    drive(0, '0, '0, 0, 0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    // fill and read-out order
    step(2, 32'hA, 32'hB, 0, 0, 0, 0);
    step(2, 32'hC, 32'hD, 0, 0, 0, 0);
    peek();
    chk("t1_deq_v", 64'(bus.deq_v_o), 64'(2'b11));
    chk("t1_lane0", 64'(bus.deq_data_o[0 +: W]), 64'(32'hA));
    chk("t1_lane1", 64'(bus.deq_data_o[W +: W]), 64'(32'hB));
    chk("t1_occupancy", 64'(bus.occupancy_o), 64'(4));
    // full, then commit frees space
    step(2, 32'hE, 32'hF, 0, 0, 0, 0);
    step(2, 32'h10, 32'h11, 0, 0, 0, 0);
    peek();
    chk("t2_full_ready", 64'(bus.enq_ready_o), 64'(0));
    chk("t2_full_occ", 64'(bus.occupancy_o), 64'(8));
    step(0, '0, '0, 2, 0, 0, 0);
    step(0, '0, '0, 0, 2, 0, 0);
    peek();
    chk("t2_ready_after_commit", 64'(bus.enq_ready_o), 64'(1));
    // roll to checkpoint
    do_reset();
    step(2, 32'hA, 32'hB, 0, 0, 0, 0);
    step(2, 32'hC, 32'hD, 0, 0, 0, 0);
    step(0, '0, '0, 2, 0, 0, 0);
    step(0, '0, '0, 0, 1, 1, 0);
    peek();
    chk("t3_lane0", 64'(bus.deq_data_o[0 +: W]), 64'(32'hB));
    chk("t3_lane1", 64'(bus.deq_data_o[W +: W]), 64'(32'hC));
    // clear unread, issued entry still committable
    do_reset();
    step(2, 32'hA, 32'hB, 0, 0, 0, 0);
    step(2, 32'hC, 32'hD, 0, 0, 0, 0);
    step(0, '0, '0, 1, 0, 0, 1);
    peek();
    chk("t4_deq_v", 64'(bus.deq_v_o), 64'(0));
    chk("t4_occupancy", 64'(bus.occupancy_o), 64'(1));
    step(0, '0, '0, 0, 1, 0, 0);
    peek();
    chk("t4_occ_after_commit", 64'(bus.occupancy_o), 64'(0));
    // index wrap with pointers parked at slot 7
    do_reset();
    for (int i = 0; i < 4; i++) step(i < 3 ? 2 : 1, W'(i * 2 + 1), W'(i * 2 + 2), 0, 0, 0, 0);
    peek();
    chk("t5_ready_at_7", 64'(bus.enq_ready_o), 64'(0));
    step(0, '0, '0, 2, 0, 0, 0);
    step(0, '0, '0, 2, 2, 0, 0);
    step(0, '0, '0, 2, 2, 0, 0);
    step(0, '0, '0, 1, 2, 0, 0);
    step(0, '0, '0, 0, 1, 0, 0);
    step(2, 32'h5A5A, 32'h7E7E, 0, 0, 0, 0);
    peek();
    chk("t5_lane0", 64'(bus.deq_data_o[0 +: W]), 64'(32'h5A5A));
    chk("t5_lane1", 64'(bus.deq_data_o[W +: W]), 64'(32'h7E7E));
    // async reset with 5 entries held
    do_reset();
    step(2, 32'h1, 32'h2, 0, 0, 0, 0);
    step(2, 32'h3, 32'h4, 0, 0, 0, 0);
    step(1, 32'h5, 32'h0, 0, 0, 0, 0);
    do_reset();
    peek();
    chk("t6_occupancy", 64'(bus.occupancy_o), 64'(0));
    chk("t6_ready", 64'(bus.enq_ready_o), 64'(1));
    // random legal traffic
    for (int c = 0; c < 4000; c++) begin
      roll = ($urandom_range(0, 9) == 0);
      clr = ($urandom_range(0, 15) == 0);
      ne = exp_ready(clr) ? int'($urandom_range(0, L)) : 0;
      unr = mq.size() - nrd;
      vl = roll ? 0 : (unr < L ? unr : L);
      yumi = int'($urandom_range(0, vl));
      cm = int'($urandom_range(0, nrd < L ? nrd : L));
      step(ne, $urandom, $urandom, yumi, cm, roll, clr);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
